// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator-side controller between the MEM pipeline stage and a
// multi-cycle, word-addressed data memory.
//   clk, rst                 clock, asynchronous active-low reset
//   MEMread, MEMwrite        pipeline request levels (write wins when both high)
//   address, data            byte address / write data from the pipeline
//   MEM_result               held read data (cleared by an illegal read)
//   stall                    combinational pipeline freeze while a request is pending
//   ready, addr_err          one-cycle completion pulse, error qualifier
//   mem_addr, mem_wdata      word index / write data to memory (0 when not accessing)
//   mem_re, mem_we           memory strobes; mem_we only in the last access cycle
//   mem_rdata                read data from memory
module mem_access_ctrl #(
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned ADDR_WORDS  = 65536,
   parameter int unsigned WAIT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEMread,
   input  logic        MEMwrite,
   input  logic [31:0] address,
   input  logic [31:0] data,
   output logic [31:0] MEM_result,
   output logic        stall,
   output logic        ready,
   output logic        addr_err,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned IDX_W = 16;
   localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              write_q, write_d;
   logic              err_q, err_d;
   logic [IDX_W-1:0]  mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       result_q, result_d;
   logic              mem_re_q, mem_re_d;
   logic              mem_we_q, mem_we_d;
   logic              ready_q, ready_d;
   logic              addr_err_q, addr_err_d;

   logic              req;
   logic              illegal;
   logic [31:0]       offset;
   logic [29:0]       word_idx;

   // Address decode: byte offset from the base, word index and legality.
   always_comb begin
      req      = MEMread | MEMwrite;
      offset   = address - 32'(BASE_ADDR);
      word_idx = 30'(offset >> 2);
      illegal  = (address < 32'(BASE_ADDR)) ||
                 (address[1:0] != 2'b00) ||
                 ({2'b00, word_idx} >= 32'(ADDR_WORDS));
   end

   // Next state, latched request and next registered outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      err_d       = err_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      result_d    = result_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               write_d = MEMwrite;
               if (illegal) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
                  if (!MEMwrite) begin
                     result_d = '0;
                  end
               end else begin
                  state_d     = ST_ACCESS;
                  cnt_d       = '0;
                  err_d       = 1'b0;
                  mem_addr_d  = word_idx[IDX_W-1:0];
                  mem_wdata_d = data;
               end
            end
         end
         ST_ACCESS: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d     = ST_DONE;
               cnt_d       = '0;
               err_d       = 1'b0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
               if (!write_q) begin
                  result_d = mem_rdata;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Strobes are decoded from the next state so they line up with ACCESS/DONE.
      mem_re_d   = (state_d == ST_ACCESS) && !write_d;
      mem_we_d   = (state_d == ST_ACCESS) && write_d && (cnt_d == CNT_LAST);
      ready_d    = (state_d == ST_DONE);
      addr_err_d = (state_d == ST_DONE) && err_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         err_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         result_q    <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         ready_q     <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         err_q       <= err_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         result_q    <= result_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         ready_q     <= ready_d;
         addr_err_q  <= addr_err_d;
      end
   end

   // Stall covers the request cycle in IDLE and the whole access.
   always_comb begin
      stall = ((state_q == ST_IDLE) && req) || (state_q == ST_ACCESS);
   end

   assign MEM_result = result_q;
   assign ready      = ready_q;
   assign addr_err   = addr_err_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_re     = mem_re_q;
   assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_mem_access_ctrl;

   localparam int unsigned BASE  = 1024;
   localparam int unsigned WORDS = 65536;
   localparam int unsigned WAITC = 4;

   logic        clk;
   logic        rst;
   logic        MEMread;
   logic        MEMwrite;
   logic [31:0] address;
   logic [31:0] data;
   logic [31:0] MEM_result;
   logic        stall;
   logic        ready;
   logic        addr_err;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   mem_access_ctrl #(
      .BASE_ADDR   (BASE),
      .ADDR_WORDS  (WORDS),
      .WAIT_CYCLES (WAITC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .MEMread    (MEMread),
      .MEMwrite   (MEMwrite),
      .address    (address),
      .data       (data),
      .MEM_result (MEM_result),
      .stall      (stall),
      .ready      (ready),
      .addr_err   (addr_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // An accepted request expands into a timeline of expected output cycles;
   // with the timeline empty the controller is idle.
   typedef struct {
      logic        re;
      logic        we;
      logic        rdy;
      logic        err;
      logic        stl;
      logic        cap;
      logic [15:0] addr;
      logic [31:0] wd;
   } exp_t;

   exp_t        tl[$];
   logic [31:0] m_result = '0;

   always @(negedge clk) begin
      exp_t             e;
      logic             was_idle;
      logic             req;
      logic             bad;
      longint unsigned  a;
      longint unsigned  widx;
      req = MEMread | MEMwrite;
      if (!rst) begin
         tl.delete();
         m_result = '0;
      end
      was_idle = (tl.size() == 0);
      if (!was_idle) begin
         e = tl.pop_front();
      end else begin
         e = '{re: 1'b0, we: 1'b0, rdy: 1'b0, err: 1'b0, stl: req, cap: 1'b0,
               addr: 16'h0, wd: 32'h0};
      end
      cmp("m_result",   MEM_result,        m_result);
      cmp("m_stall",    32'(stall),        32'(e.stl));
      cmp("m_ready",    32'(ready),        32'(e.rdy));
      cmp("m_addr_err", 32'(addr_err),     32'(e.err));
      cmp("m_mem_addr", 32'(mem_addr),     32'(e.addr));
      cmp("m_wdata",    mem_wdata,         e.wd);
      cmp("m_re",       32'(mem_re),       32'(e.re));
      cmp("m_we",       32'(mem_we),       32'(e.we));
      if (e.cap) m_result = mem_rdata;
      if (rst && was_idle && req) begin
         a    = 64'(address);
         widx = (a >= BASE) ? (a - BASE) / 4 : 0;
         bad  = (a < BASE) || (a % 4 != 0) || (widx >= WORDS);
         if (bad) begin
            if (!MEMwrite) m_result = '0;
         end else begin
            for (int k = 0; k < int'(WAITC); k++) begin
               tl.push_back('{re: !MEMwrite, we: MEMwrite && (k == int'(WAITC) - 1),
                              rdy: 1'b0, err: 1'b0, stl: 1'b1,
                              cap: !MEMwrite && (k == int'(WAITC) - 1),
                              addr: 16'(widx % WORDS), wd: data});
            end
         end
         tl.push_back('{re: 1'b0, we: 1'b0, rdy: 1'b1, err: bad, stl: 1'b0, cap: 1'b0,
                        addr: 16'h0, wd: 32'h0});
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] d);
      MEMread  = r;
      MEMwrite = w;
      address  = ad;
      data     = d;
   endtask

   initial begin
      int           we_n;
      int           re_n;
      int           rdy_n;
      logic [31:0]  bad_addr [3];
      rst       = 1'b0;
      mem_rdata = 32'hDEADBEEF;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      cmp("reset_result", MEM_result, 32'h0);
      cmp("reset_ready",  32'(ready),  32'h0);
      cmp("reset_maddr",  32'(mem_addr), 32'h0);
      cyc();
      rst = 1'b1;
      cyc();

      // Legal read at 1032 -> word 2.
      drive(1'b1, 1'b0, 32'd1032, 32'h0);
      @(negedge clk);
      cmp("rd_c0_stall", 32'(stall), 32'h1);
      for (int c = 1; c <= 5; c++) begin
         cyc();
         if (c == 1) drive(1'b0, 1'b0, 32'h0, 32'h0);
         @(negedge clk);
         if (c <= 4) begin
            cmp("rd_addr",  32'(mem_addr), 32'd2);
            cmp("rd_re",    32'(mem_re),   32'h1);
            cmp("rd_stall", 32'(stall),    32'h1);
         end else begin
            cmp("rd_ready",  32'(ready), 32'h1);
            cmp("rd_stall5", 32'(stall), 32'h0);
            cmp("rd_result", MEM_result, 32'hDEADBEEF);
         end
      end

      // Legal write at 1024 -> word 0, write strobe only in cycle 4.
      cyc();
      drive(1'b0, 1'b1, 32'd1024, 32'h12345678);
      @(negedge clk);
      for (int c = 1; c <= 5; c++) begin
         cyc();
         if (c == 1) drive(1'b0, 1'b0, 32'h0, 32'h0);
         @(negedge clk);
         if (c <= 4) begin
            cmp("wr_we", 32'(mem_we), 32'(c == 4));
            cmp("wr_re", 32'(mem_re), 32'h0);
            if (c == 4) cmp("wr_wdata", mem_wdata, 32'h12345678);
         end else begin
            cmp("wr_ready",  32'(ready), 32'h1);
            cmp("wr_result", MEM_result, 32'hDEADBEEF);
         end
      end

      // Simultaneous read+write at 1028 -> write to word 1.
      cyc();
      drive(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D);
      @(negedge clk);
      we_n = 0;
      re_n = 0;
      for (int c = 1; c <= 5; c++) begin
         cyc();
         if (c == 1) drive(1'b0, 1'b0, 32'h0, 32'h0);
         @(negedge clk);
         we_n += int'(mem_we);
         re_n += int'(mem_re);
         if (c == 4) cmp("rw_addr", 32'(mem_addr), 32'd1);
         if (c == 5) cmp("rw_ready", 32'(ready), 32'h1);
      end
      cmp("rw_we_pulses", 32'(we_n), 32'd1);
      cmp("rw_re_pulses", 32'(re_n), 32'd0);

      // Illegal addresses: below base, misaligned, beyond the last word.
      bad_addr[0] = 32'd1000;
      bad_addr[1] = 32'd1026;
      bad_addr[2] = 32'd263168;
      for (int i = 0; i < 3; i++) begin
         cyc();
         drive(1'b1, 1'b0, bad_addr[i], 32'h0);
         @(negedge clk);
         cyc();
         drive(1'b0, 1'b0, 32'h0, 32'h0);
         @(negedge clk);
         cmp("ill_ready",  32'(ready),    32'h1);
         cmp("ill_err",    32'(addr_err), 32'h1);
         cmp("ill_re",     32'(mem_re),   32'h0);
         cmp("ill_we",     32'(mem_we),   32'h0);
         cmp("ill_result", MEM_result,    32'h0);
      end

      // Reset in access cycle 2 of a write.
      cyc();
      drive(1'b0, 1'b1, 32'd1032, 32'h55AA55AA);
      @(negedge clk);
      we_n = 0;
      cyc();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      we_n += int'(mem_we);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      we_n += int'(mem_we);
      cmp("rst_we_seen", 32'(we_n),   32'd0);
      cmp("rst_stall",   32'(stall),  32'h0);
      cmp("rst_ready",   32'(ready),  32'h0);
      cmp("rst_maddr",   32'(mem_addr), 32'h0);
      cmp("rst_wdata",   mem_wdata,   32'h0);
      cmp("rst_result",  MEM_result,  32'h0);
      cyc();
      drive(1'b1, 1'b0, 32'd1036, 32'h0);
      @(negedge clk);
      cmp("rst_req_stall", 32'(stall), 32'h1);
      cyc();
      rst = 1'b1;
      @(negedge clk);
      cyc();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      cmp("post_rst_re",   32'(mem_re),   32'h1);
      cmp("post_rst_addr", 32'(mem_addr), 32'd3);
      repeat (6) cyc();

      // Back-to-back reads with the request held high.
      mem_rdata = 32'hAAAA0001;
      drive(1'b1, 1'b0, 32'd1024, 32'h0);
      @(negedge clk);
      rdy_n = 0;
      for (int c = 1; c <= 12; c++) begin
         cyc();
         if (c == 5)  mem_rdata = 32'hBBBB0002;
         if (c == 6)  address = 32'd1028;
         if (c == 12) drive(1'b0, 1'b0, 32'h0, 32'h0);
         @(negedge clk);
         if (c <= 11) rdy_n += int'(ready);
         if (c == 5) begin
            cmp("b2b_ready1",  32'(ready), 32'h1);
            cmp("b2b_result1", MEM_result, 32'hAAAA0001);
         end
         if (c == 6) begin
            cmp("b2b_c6_ready", 32'(ready), 32'h0);
            cmp("b2b_c6_stall", 32'(stall), 32'h1);
         end
         if (c == 8) cmp("b2b_addr2", 32'(mem_addr), 32'd1);
         if (c == 11) begin
            cmp("b2b_ready2",  32'(ready), 32'h1);
            cmp("b2b_result2", MEM_result, 32'hBBBB0002);
         end
      end
      cmp("b2b_pulses", 32'(rdy_n), 32'd2);

      // Randomized traffic, checked by the model every cycle.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] ad;
         cyc();
         if (!rst) rst = 1'b1;
         else if ($urandom_range(0, 299) == 0) rst = 1'b0;
         case ($urandom_range(0, 7))
            0:       ad = $urandom;
            1:       ad = 32'(BASE) - 32'(4 * $urandom_range(1, 256));
            2:       ad = 32'(BASE) + 32'(4 * $urandom_range(0, 1000)) + 32'($urandom_range(1, 3));
            3:       ad = 32'(BASE) + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 100));
            4:       ad = 32'(BASE) + 32'(4 * (WORDS - 1));
            default: ad = 32'(BASE) + 32'(4 * $urandom_range(0, WORDS - 1));
         endcase
         drive(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0), ad, $urandom);
         mem_rdata = $urandom;
      end

      cyc();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (8) cyc();
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
